// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// the bit-period helper used to derive BPS from clock and line rates.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Clock cycles per bit period for a given system clock and baud rate.
  function automatic int calc_bps(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake between a byte source and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BPS-1 while enabled and flags the last
// cycle of each bit period. Shared between the TX and RX paths.
module uart_baud_cnt #(
  parameter int BPS   = 5208,
  parameter int CNT_W = $clog2(BPS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS - 1);

  logic [CNT_W-1:0] cnt;

  // Advance and wrap the period counter; a clear holds it at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: accepts one word per valid/ready
// handshake and sends start, LSB-first data, optional parity and stop bits
// on a registered, idle-high txd line.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int BPS       = calc_bps(CLK_FREQ, BAUD),
  parameter int CNT_W     = $clog2(BPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_frame_if.slave   bus,
  output logic             txd
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (BPS < 2) begin : g_bad_bps
    $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            state, state_d;
  logic [3:0]           bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_bit, par_bit_d;
  logic                 txd_d;
  logic                 done_d;
  logic                 tx_done_q;
  logic                 bit_end;

  uart_baud_cnt #(
    .BPS   (BPS),
    .CNT_W (CNT_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != S_IDLE),
    .clr     (state == S_IDLE),
    .bit_end (bit_end)
  );

  // Next-state, datapath and registered-output decode for the frame FSM.
  // NOTE: every signal gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    par_bit_d = par_bit;
    done_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.tx_valid) begin
          state_d   = S_START;
          bit_idx_d = '0;
          shift_d   = bus.tx_data;
          par_bit_d = (PARITY == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // txd is registered, so it is decoded from the state being entered.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset forces the idle-high line.
  // NOTE: the shift register is reset along with the control state; it is
  // a handful of flops, not a memory, so the reset costs nothing real.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      txd       <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      par_bit   <= par_bit_d;
      txd       <= txd_d;
      tx_done_q <= done_d;
    end
  end

  assign bus.tx_ready = (state == S_IDLE);
  assign bus.tx_busy  = (state != S_IDLE);
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: five frame formats at 10 clocks/bit,
// exercised through a shared stimulus/observation mux.
module tb_uart_tx_frame;

  localparam int BPS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [8:0] data = '0;
  int         sel = 0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_q[$];

  logic txd0, txd1, txd2, txd3, txd4;
  logic txd_m, ready_m, busy_m, done_m;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if3 ();
  uart_tx_frame_if #(.DATA_BITS(9)) if4 ();

  assign if0.tx_valid = valid && (sel == 0);
  assign if1.tx_valid = valid && (sel == 1);
  assign if2.tx_valid = valid && (sel == 2);
  assign if3.tx_valid = valid && (sel == 3);
  assign if4.tx_valid = valid && (sel == 4);
  assign if0.tx_data  = data[7:0];
  assign if1.tx_data  = data[7:0];
  assign if2.tx_data  = data[7:0];
  assign if3.tx_data  = data[6:0];
  assign if4.tx_data  = data[8:0];

  // 8N1
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .txd(txd0));
  // 8E1
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .txd(txd1));
  // 8O1
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .txd(txd2));
  // 7N2
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .txd(txd3));
  // 9N1
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(9),
                  .PARITY(0), .STOP_BITS(1))
    u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .txd(txd4));

  always #5 clk = ~clk;

  always_comb begin
    txd_m = txd0; ready_m = if0.tx_ready; busy_m = if0.tx_busy; done_m = if0.tx_done;
    case (sel)
      1: begin txd_m = txd1; ready_m = if1.tx_ready; busy_m = if1.tx_busy; done_m = if1.tx_done; end
      2: begin txd_m = txd2; ready_m = if2.tx_ready; busy_m = if2.tx_busy; done_m = if2.tx_done; end
      3: begin txd_m = txd3; ready_m = if3.tx_ready; busy_m = if3.tx_busy; done_m = if3.tx_done; end
      4: begin txd_m = txd4; ready_m = if4.tx_ready; busy_m = if4.tx_busy; done_m = if4.tx_done; end
      default: ;
    endcase
  end

  // Log the cycle number of every handshake on the selected instance.
  always @(posedge clk) begin
    if (valid && ready_m === 1'b1) acc_q.push_back(cyc);
    cyc++;
  end

  // Called at a falling edge with valid already high; returns just after
  // the accepting rising edge.
  task automatic wait_accept(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready_m === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: tx_ready not seen within 50 cycles, required an accept", name);
    end
  endtask

  // Called just after an accepting edge; checks cycles 1..F+1 and returns
  // at the falling edge of cycle F+1.
  task automatic monitor_frame(input string name, input logic [8:0] word, input int nbits,
                               input int par, input int stops, input int exp_par);
    bit   exp_bits[16];
    int   n = 0;
    int   f;
    int   bad_txd = 0, bad_ready = 0, bad_busy = 0, bad_done = 0, first_bad = 0;
    logic par_seen = 1'bx;
    bit   x = 1'b0;

    exp_bits[n++] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      exp_bits[n++] = word[i];
      x ^= word[i];
    end
    if (par == 2) exp_bits[n++] = x;
    if (par == 1) exp_bits[n++] = ~x;
    for (int i = 0; i < stops; i++) exp_bits[n++] = 1'b1;
    f = n * BPS;

    for (int k = 1; k <= f; k++) begin
      @(negedge clk);
      if (txd_m !== exp_bits[(k-1)/BPS]) begin
        if (bad_txd == 0) first_bad = k;
        bad_txd++;
      end
      if (ready_m !== 1'b0) bad_ready++;
      if (busy_m !== 1'b1) bad_busy++;
      if (done_m !== 1'b0) bad_done++;
      if (par != 0 && k == (1 + nbits) * BPS + BPS / 2) par_seen = txd_m;
    end

    checks++;
    if (bad_txd != 0) begin
      failures++;
      $display("FAIL %s_txd: %0d wrong cycles (first at cycle %0d), required 0", name, bad_txd, first_bad);
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL %s_ready_low: %0d cycles with tx_ready!=0, required 0", name, bad_ready);
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL %s_busy_high: %0d cycles with tx_busy!=1, required 0", name, bad_busy);
    end
    checks++;
    if (bad_done != 0) begin
      failures++;
      $display("FAIL %s_done_early: %0d cycles with tx_done!=0, required 0", name, bad_done);
    end
    if (exp_par >= 0) begin
      checks++;
      if (par_seen !== exp_par[0]) begin
        failures++;
        $display("FAIL %s_parity: got %b, required %0d", name, par_seen, exp_par);
      end
    end

    @(negedge clk);
    checks++;
    if (done_m !== 1'b1 || ready_m !== 1'b1 || busy_m !== 1'b0 || txd_m !== 1'b1) begin
      failures++;
      $display("FAIL %s_end cycle %0d: done=%b ready=%b busy=%b txd=%b, required 1 1 0 1",
               name, f + 1, done_m, ready_m, busy_m, txd_m);
    end
  endtask

  task automatic send_frame(input string name, input int sel_i, input logic [8:0] word,
                            input int nbits, input int par, input int stops, input int exp_par);
    bit ok;
    @(negedge clk);
    sel   = sel_i;
    data  = word;
    valid = 1'b1;
    wait_accept(name, ok);
    #1 valid = 1'b0;
    if (ok) begin
      monitor_frame(name, word, nbits, par, stops, exp_par);
      @(negedge clk);
      checks++;
      if (done_m !== 1'b0 || txd_m !== 1'b1) begin
        failures++;
        $display("FAIL %s_after: done=%b txd=%b, required done=0 txd=1", name, done_m, txd_m);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({txd0, txd1, txd2, txd3, txd4} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_txd: got %b, required 11111", {txd0, txd1, txd2, txd3, txd4});
    end
    checks++;
    if ({if0.tx_ready, if0.tx_busy, if0.tx_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags: ready/busy/done=%b, required 100",
               {if0.tx_ready, if0.tx_busy, if0.tx_done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (txd_m !== 1'b1 || ready_m !== 1'b1 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: txd=%b ready=%b done=%b, required 1 1 0", txd_m, ready_m, done_m);
    end
  endtask

  task automatic test_formats;
    send_frame("8n1_a5", 0, 9'h0A5, 8, 0, 1, -1);
    send_frame("8e1_07", 1, 9'h007, 8, 2, 1, 1);
    send_frame("8o1_07", 2, 9'h007, 8, 1, 1, 0);
    send_frame("7n2_55", 3, 9'h055, 7, 0, 2, -1);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    @(negedge clk);
    sel   = 0;
    data  = 9'h001;
    valid = 1'b1;
    wait_accept("b2b_first", ok);
    #1 data = 9'h080;
    if (ok) begin
      monitor_frame("b2b_first", 9'h001, 8, 0, 1, -1);
      @(posedge clk);
      #1 valid = 1'b0;
      monitor_frame("b2b_second", 9'h080, 8, 0, 1, -1);
    end
    valid = 1'b0;
    n = acc_q.size();
    checks++;
    if (n < 2) begin
      failures++;
      $display("FAIL b2b_spacing: only %0d accepts logged, required 2", n);
    end else if (acc_q[n-1] - acc_q[n-2] != 101) begin
      failures++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart, required 101", acc_q[n-1] - acc_q[n-2]);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    @(negedge clk);
    sel   = 0;
    data  = 9'h000;
    valid = 1'b1;
    wait_accept("rst_mid", ok);
    #1 valid = 1'b0;
    repeat (45) @(negedge clk);
    checks++;
    if (txd_m !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_bit3_low: txd=%b, required 0", txd_m);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txd_m !== 1'b1 || ready_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: txd=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               txd_m, ready_m, busy_m, done_m);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (txd_m !== 1'b1 || ready_m !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_idle_after: txd=%b ready=%b, required 1 1", txd_m, ready_m);
    end
    send_frame("rst_then_3c", 0, 9'h03C, 8, 0, 1, -1);
  endtask

  task automatic test_boundary_data;
    send_frame("8n1_00", 0, 9'h000, 8, 0, 1, -1);
    send_frame("8n1_ff", 0, 9'h0FF, 8, 0, 1, -1);
    send_frame("9n1_1ff", 4, 9'h1FF, 9, 0, 1, -1);
    send_frame("9n1_000", 4, 9'h000, 9, 0, 1, -1);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_reset_mid_frame();
    test_boundary_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 once-per-second sender.
- Accepts one data word per valid/ready handshake and serialises it LSB-first.
- Frame format is configurable by parameter: start bit, data bits, optional parity, stop bits.
- Sits between a byte producer (FIFO or FSM) and the board TXD pin; idle line is high.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- BPS, CLK_FREQ/BAUD, clock cycles per bit (derived); must be >= 2.
- CNT_W, $clog2(BPS), width of the bit-period counter (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_data  in  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx_busy  out  1  frame in progress (not IDLE).
- tx_done  out  1  one-cycle pulse when the last stop bit completes.
- txd  out  1  serial line output, registered.

Behaviour:
- Reset (async, rst_n=0): txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. A reset mid-frame aborts the frame immediately; txd returns high with no glitch low.
- Handshake: a word is accepted on the clk edge where tx_valid && tx_ready. tx_data is latched into the shift register on that edge. tx_ready drops on the next cycle. tx_data is don't-care otherwise. tx_valid while busy is ignored and nothing is queued.
- State machine: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
- Bit timing: the bit counter runs 0..BPS-1 in every non-IDLE state. A bit ends when the counter reaches BPS-1, then the counter wraps to 0.
- txd is a registered output: txd=0 from the first cycle after acceptance, for exactly BPS cycles.
- DATA: DATA_BITS bits, LSB first, each BPS cycles. The bit index runs 0..DATA_BITS-1 and the state leaves DATA when index==DATA_BITS-1 and the counter is at BPS-1.
- PARITY: odd mode sends ~^data and even mode sends ^data, computed from the latched word, for BPS cycles.
- STOP: txd=1 for STOP_BITS*BPS cycles. On the final cycle of the last stop bit the state goes to IDLE, and tx_done=1 for exactly the following cycle, with tx_ready=1 in that same cycle.
- Frame length: F = BPS*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles of txd activity.
- Back-to-back: with tx_valid held high, accepts occur every F+1 cycles, i.e. one IDLE cycle with txd=1 between frames.
- Simultaneous events: reset has priority over everything. A handshake in the same cycle as tx_done is legal and starts the next frame.
- Illegal parameter values (DATA_BITS outside 5..9, STOP_BITS outside 1..2, PARITY>2, BPS<2) trigger an elaboration-time $error.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the state encoding typedef tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - a function that calculates BPS for a given clock frequency and baud rate.
- One natural sub-module, uart_baud_cnt: the bit-period counter with an enable input, a clear on IDLE, and a one-cycle bit_end output at BPS-1. The RX side reuses it later.
- The FSM, shift register, parity and output register stay in uart_tx_frame.

Test Plan:
- Single 8N1 word (CLK_FREQ=1_000_000, BAUD=100_000, BPS=10): accept 0xA5 -> txd low for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10 cycles; tx_done pulses at cycle 101 after accept; tx_ready=0 throughout the frame.
- Even parity 8E1, word 0x07 -> parity bit 1; odd 8O1, word 0x07 -> parity bit 0; frame is 110 cycles in both cases.
- 7-bit data with 2 stop bits, word 0x55 -> 7 data bits 1,0,1,0,1,0,1, then txd high for 20 cycles; tx_done at cycle 101.
- Back-to-back: tx_valid held high with words 0x01 then 0x80 -> second accept exactly 101 cycles after the first, with one idle-high cycle between frames; tx_valid asserted mid-frame has no effect.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> txd=1 and tx_ready=1 immediately (asynchronous); after release a new word 0x3C transmits a correct full frame.
- Boundary data: send 0x00 and 0xFF in 8N1 and 9-bit mode (0x1FF) -> correct bit count and line high after the stop bits; no extra or missing bit periods.
